// File: rtl/unidade_controle_pkg.sv
// Shared constants and types for the bus processor control sequencer.
package unidade_controle_pkg;

    localparam int IR_W  = 16;
    localparam int NREGS = 8;

    // Timesteps of one instruction
    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_t;

    // Opcodes held in IR[15:12]
    localparam logic [3:0] OP_MV   = 4'd0;
    localparam logic [3:0] OP_MVI  = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_SLT  = 4'd5;
    localparam logic [3:0] OP_LD   = 4'd6;
    localparam logic [3:0] OP_ST   = 4'd7;
    localparam logic [3:0] OP_MVNZ = 4'd8;

    // Bus mux selects (0-7 pick R0-R7 directly)
    localparam logic [3:0] SEL_G    = 4'd8;
    localparam logic [3:0] SEL_DIN  = 4'd9;
    localparam logic [3:0] SEL_NONE = 4'd15;

    // ALU operations
    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;
    localparam logic [1:0] ALU_AND = 2'd2;
    localparam logic [1:0] ALU_SLT = 2'd3;

    // Register index to bus select code
    function automatic logic [3:0] sel_reg(input logic [2:0] r);
        return {1'b0, r};
    endfunction

endpackage

// File: rtl/unidade_controle_decodificador_reg.sv
// Register index to one-hot write-enable decoder for the register file.
module decodificador_reg #(
    parameter int NREGS = 8,
    parameter int IDX_W = 3
) (
    input  logic [IDX_W-1:0] idx,
    input  logic             en,
    output logic [NREGS-1:0] onehot
);

    // At most one bit set, and only when a write is requested
    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/unidade_controle.sv
// Control sequencer: decodes IR and steps T0..T3, driving register strobes,
// bus select, ALU op, memory write and done. All outputs are combinational
// so the negedge-sampling registers capture them within the same cycle.
//
// state | meaning
// T0    | idle / fetch: load IR from DIN when run is high
// T1    | first execute step (moves finish here)
// T2    | second step (ALU operand B, memory wait, store)
// T3    | write-back of ALU result or loaded word
module unidade_controle
    import unidade_controle_pkg::*;
#(
    parameter int IR_W_P  = IR_W,
    parameter int NREGS_P = NREGS
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               run,
    input  logic [IR_W_P-1:0]  ir,
    input  logic               g_nz,
    output logic               ir_wren,
    output logic [NREGS_P-1:0] r_wren,
    output logic               a_wren,
    output logic               g_wren,
    output logic               addr_wren,
    output logic               dout_wren,
    output logic               mem_wr,
    output logic [3:0]         bus_sel,
    output logic [1:0]         alu_op,
    output logic               done
);

    state_t     state;
    state_t     next_state;
    logic [3:0] op;
    logic [2:0] rx;
    logic [2:0] ry;
    logic       r_en;
    logic       unused_ir_bits;

    assign op = ir[IR_W_P-1 -: 4];
    assign rx = ir[IR_W_P-5 -: 3];
    assign ry = ir[IR_W_P-8 -: 3];
    assign unused_ir_bits = ^ir[IR_W_P-11:0];

    // State register; reset abandons any instruction in flight
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= T0;
        end else begin
            state <= next_state;
        end
    end

    // Next-state: done always returns to T0, otherwise advance one step
    always_comb begin
        next_state = state;
        if (reset) begin
            next_state = T0;
        end else begin
            case (state)
                T0: next_state = run  ? T1 : T0;
                T1: next_state = done ? T0 : T2;
                T2: next_state = done ? T0 : T3;
                T3: next_state = T0;
            endcase
        end
    end

    // Outputs: per-step micro-operations decoded from the opcode
    always_comb begin
        ir_wren   = 1'b0;
        a_wren    = 1'b0;
        g_wren    = 1'b0;
        addr_wren = 1'b0;
        dout_wren = 1'b0;
        mem_wr    = 1'b0;
        bus_sel   = SEL_NONE;
        alu_op    = ALU_ADD;
        done      = 1'b0;
        r_en      = 1'b0;
        if (!reset) begin
            case (state)
                T0: begin
                    if (run) begin
                        ir_wren = 1'b1;
                        bus_sel = SEL_DIN;
                    end
                end
                T1: begin
                    case (op)
                        OP_MV: begin
                            bus_sel = sel_reg(ry);
                            r_en    = 1'b1;
                            done    = 1'b1;
                        end
                        OP_MVI: begin
                            bus_sel = SEL_DIN;
                            r_en    = 1'b1;
                            done    = 1'b1;
                        end
                        OP_ADD, OP_SUB, OP_AND, OP_SLT: begin
                            bus_sel = sel_reg(rx);
                            a_wren  = 1'b1;
                        end
                        OP_LD, OP_ST: begin
                            bus_sel   = sel_reg(ry);
                            addr_wren = 1'b1;
                        end
                        OP_MVNZ: begin
                            if (g_nz) begin
                                bus_sel = sel_reg(ry);
                                r_en    = 1'b1;
                            end
                            done = 1'b1;
                        end
                        default: done = 1'b1;
                    endcase
                end
                T2: begin
                    case (op)
                        OP_ADD, OP_SUB, OP_AND, OP_SLT: begin
                            bus_sel = sel_reg(ry);
                            g_wren  = 1'b1;
                            alu_op  = 2'(op - OP_ADD);
                        end
                        OP_ST: begin
                            bus_sel   = sel_reg(rx);
                            dout_wren = 1'b1;
                            mem_wr    = 1'b1;
                            done      = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T3: begin
                    case (op)
                        OP_ADD, OP_SUB, OP_AND, OP_SLT: begin
                            bus_sel = SEL_G;
                            r_en    = 1'b1;
                            done    = 1'b1;
                        end
                        OP_LD: begin
                            bus_sel = SEL_DIN;
                            r_en    = 1'b1;
                            done    = 1'b1;
                        end
                        default: ;
                    endcase
                end
            endcase
        end
    end

    decodificador_reg #(
        .NREGS (NREGS_P),
        .IDX_W (3)
    ) u_dec (
        .idx    (rx),
        .en     (r_en),
        .onehot (r_wren)
    );

endmodule

// File: tb/tb_unidade_controle.sv
// Bench for unidade_controle: per-instruction micro-op scripts built from
// the ISA description, compared cycle by cycle against the DUT outputs.
module tb_unidade_controle;

    typedef struct packed {
        logic       ir_wren;
        logic [7:0] r_wren;
        logic       a_wren;
        logic       g_wren;
        logic       addr_wren;
        logic       dout_wren;
        logic       mem_wr;
        logic [3:0] bus_sel;
        logic [1:0] alu_op;
        logic       done;
    } vec_t;

    logic        clock;
    logic        reset;
    logic        run;
    logic [15:0] ir;
    logic        g_nz;
    logic        ir_wren;
    logic [7:0]  r_wren;
    logic        a_wren;
    logic        g_wren;
    logic        addr_wren;
    logic        dout_wren;
    logic        mem_wr;
    logic [3:0]  bus_sel;
    logic [1:0]  alu_op;
    logic        done;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    vec_t exp_q[$];
    vec_t obs;

    unidade_controle dut (
        .clock     (clock),
        .reset     (reset),
        .run       (run),
        .ir        (ir),
        .g_nz      (g_nz),
        .ir_wren   (ir_wren),
        .r_wren    (r_wren),
        .a_wren    (a_wren),
        .g_wren    (g_wren),
        .addr_wren (addr_wren),
        .dout_wren (dout_wren),
        .mem_wr    (mem_wr),
        .bus_sel   (bus_sel),
        .alu_op    (alu_op),
        .done      (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic vec_t idle_v();
        vec_t v;
        v = '0;
        v.bus_sel = 4'd15;
        return v;
    endfunction

    function automatic vec_t fetch_v();
        vec_t v;
        v = idle_v();
        v.ir_wren = 1'b1;
        v.bus_sel = 4'd9;
        return v;
    endfunction

    function automatic int latency_of(input logic [15:0] w);
        int o;
        o = int'(w[15:12]);
        if (o >= 2 && o <= 6) return 4;
        if (o == 7) return 3;
        return 2;
    endfunction

    // Script of execute steps (T1 onward) for one instruction
    task automatic build_steps(input logic [15:0] w, input logic gnz);
        int         o;
        int         rx;
        int         ry;
        logic [7:0] hot;
        vec_t       v;
        o   = int'(w[15:12]);
        rx  = int'(w[11:9]);
        ry  = int'(w[8:6]);
        hot = 8'(1 << rx);
        exp_q.delete();
        if (o == 0 || o == 1) begin
            v = idle_v();
            v.bus_sel = (o == 0) ? 4'(ry) : 4'd9;
            v.r_wren = hot;
            v.done = 1'b1;
            exp_q.push_back(v);
        end else if (o >= 2 && o <= 5) begin
            v = idle_v(); v.bus_sel = 4'(rx); v.a_wren = 1'b1;
            exp_q.push_back(v);
            v = idle_v(); v.bus_sel = 4'(ry); v.g_wren = 1'b1; v.alu_op = 2'(o - 2);
            exp_q.push_back(v);
            v = idle_v(); v.bus_sel = 4'd8; v.r_wren = hot; v.done = 1'b1;
            exp_q.push_back(v);
        end else if (o == 6) begin
            v = idle_v(); v.bus_sel = 4'(ry); v.addr_wren = 1'b1;
            exp_q.push_back(v);
            exp_q.push_back(idle_v());
            v = idle_v(); v.bus_sel = 4'd9; v.r_wren = hot; v.done = 1'b1;
            exp_q.push_back(v);
        end else if (o == 7) begin
            v = idle_v(); v.bus_sel = 4'(ry); v.addr_wren = 1'b1;
            exp_q.push_back(v);
            v = idle_v(); v.bus_sel = 4'(rx); v.dout_wren = 1'b1; v.mem_wr = 1'b1; v.done = 1'b1;
            exp_q.push_back(v);
        end else if (o == 8) begin
            v = idle_v();
            if (gnz) begin
                v.bus_sel = 4'(ry);
                v.r_wren = hot;
            end
            v.done = 1'b1;
            exp_q.push_back(v);
        end else begin
            v = idle_v();
            v.done = 1'b1;
            exp_q.push_back(v);
        end
    endtask

    task automatic sample();
        @(negedge clock);
        cyc++;
        obs = {ir_wren, r_wren, a_wren, g_wren, addr_wren, dout_wren, mem_wr, bus_sel, alu_op, done};
    endtask

    task automatic next_edge();
        @(posedge clock);
        #1;
    endtask

    // Execute one instruction from its T0; run may be randomized after T0
    task automatic run_instr(input logic [15:0] w, input logic gnz, input bit rand_run,
                             input string nm, output int lat);
        build_steps(w, gnz);
        ir = w;
        g_nz = gnz;
        run = 1'b1;
        lat = 1;
        sample();
        total++;
        if (obs !== fetch_v()) begin
            bad++;
            $display("FAIL %s_t0: got %h expected %h", nm, obs, fetch_v());
        end
        next_edge();
        foreach (exp_q[i]) begin
            run = rand_run ? 1'($urandom_range(0, 1)) : 1'b1;
            sample();
            lat++;
            total++;
            if (obs !== exp_q[i]) begin
                bad++;
                $display("FAIL %s_t%0d: ir=%h got %h expected %h", nm, i + 1, w, obs, exp_q[i]);
            end
            next_edge();
        end
    endtask

    task automatic test_reset();
        int lat;
        reset = 1'b1; run = 1'b1; ir = 16'h2280; g_nz = 1'b0;
        repeat (2) begin
            sample();
            total++;
            if (obs !== idle_v()) begin
                bad++;
                $display("FAIL rst_hold: got %h expected %h", obs, idle_v());
            end
            next_edge();
        end
        reset = 1'b0; run = 1'b0;
        sample();
        total++;
        if (obs !== idle_v()) begin
            bad++;
            $display("FAIL rst_idle: got %h expected %h", obs, idle_v());
        end
        next_edge();
        // add R1,R2 interrupted in T2
        build_steps(16'h2280, 1'b0);
        run = 1'b1;
        sample();
        total++;
        if (obs !== fetch_v()) begin
            bad++;
            $display("FAIL rst_add_t0: got %h expected %h", obs, fetch_v());
        end
        next_edge();
        run = 1'b0;
        sample();
        total++;
        if (obs !== exp_q[0]) begin
            bad++;
            $display("FAIL rst_add_t1: got %h expected %h", obs, exp_q[0]);
        end
        next_edge();
        reset = 1'b1;
        repeat (2) begin
            sample();
            total++;
            if (obs !== idle_v()) begin
                bad++;
                $display("FAIL rst_mid: got %h expected %h", obs, idle_v());
            end
            next_edge();
        end
        reset = 1'b0;
        repeat (3) begin
            sample();
            total++;
            if (obs !== idle_v()) begin
                bad++;
                $display("FAIL rst_after: got %h expected %h", obs, idle_v());
            end
            next_edge();
        end
        run_instr(16'h0000, 1'b0, 1'b0, "rst_mv", lat);
        run = 1'b0;
    endtask

    task automatic test_mvi();
        int lat;
        run_instr(16'h1600, 1'b0, 1'b1, "mvi", lat);
        run = 1'b0;
        total++;
        if (lat !== 2) begin
            bad++;
            $display("FAIL mvi_latency: got %0d expected 2", lat);
        end
        sample();
        total++;
        if (obs !== idle_v()) begin
            bad++;
            $display("FAIL mvi_idle_after: got %h expected %h", obs, idle_v());
        end
        next_edge();
    endtask

    task automatic test_alu_st_mvnz();
        int lat;
        run_instr(16'h2280, 1'b0, 1'b1, "add", lat);
        total++;
        if (lat !== 4) begin
            bad++;
            $display("FAIL add_latency: got %0d expected 4", lat);
        end
        run_instr(16'h7440, 1'b1, 1'b1, "st", lat);
        total++;
        if (lat !== 3) begin
            bad++;
            $display("FAIL st_latency: got %0d expected 3", lat);
        end
        run_instr(16'h8A00, 1'b0, 1'b1, "mvnz_z", lat);
        run_instr(16'h8A00, 1'b1, 1'b1, "mvnz_nz", lat);
        run_instr(16'h5B40, 1'b0, 1'b1, "slt", lat);
        run_instr(16'h66C0, 1'b0, 1'b1, "ld_same", lat);
        run = 1'b0;
        next_edge();
    endtask

    task automatic test_back_to_back();
        int lat;
        int base;
        int done_at[$];
        logic [15:0] prog[3];
        prog[0] = 16'h0440;
        prog[1] = 16'h6A80;
        prog[2] = 16'hF000;
        base = cyc;
        foreach (prog[k]) begin
            run_instr(prog[k], 1'b0, 1'b0, "b2b", lat);
            done_at.push_back(cyc - base);
        end
        run = 1'b0;
        total++;
        if (done_at[0] != 2 || done_at[1] != 6 || done_at[2] != 8) begin
            bad++;
            $display("FAIL b2b_done_cycles: got %0d,%0d,%0d expected 2,6,8",
                     done_at[0], done_at[1], done_at[2]);
        end
        next_edge();
    endtask

    task automatic test_random();
        int lat;
        logic [15:0] w;
        for (int n = 0; n < 40; n++) begin
            w = 16'($urandom);
            run_instr(w, 1'($urandom_range(0, 1)), 1'b1, "rand", lat);
            total++;
            if (lat !== latency_of(w)) begin
                bad++;
                $display("FAIL rand_latency: ir=%h got %0d expected %0d", w, lat, latency_of(w));
            end
            run = 1'b0;
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
                sample();
                total++;
                if (obs !== idle_v()) begin
                    bad++;
                    $display("FAIL rand_gap: got %h expected %h", obs, idle_v());
                end
                next_edge();
            end
        end
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; ir = '0; g_nz = 1'b0;
        #1;
        test_reset();
        test_mvi();
        test_alu_st_mvnz();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
